// File: rtl/keypad_code_ctrl.sv
// keypad_code_ctrl
//   PIN-entry controller between the keypad scanner and the alarm FSM.
//   Collects a 4-digit PIN plus a command key (ARM/DISARM), compares the PIN
//   against a stored code and, on a match, drives the alarm FSM keypad bus
//   with the arm (0011) or disarm (1100) code for CMD_HOLD enabled cycles.
//   Consecutive failures are counted; MAX_FAIL failures start a timed lockout.
//
// Optional feature macro: KEYPAD_DURESS_EN
//   When defined, a PIN whose last digit is PIN[3:0]+1 (mod 10) followed by
//   DISARM issues a normal disarm and latches the duress flag until reset.
//   When undefined, duress is constantly 0 and that code is a plain failure.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset (ignores ENA)
//   ENA        in   clock enable; all state advances only when high
//   key_valid  in   one-cycle strobe qualifying key_code
//   key_code   in   0-9 digit, A=ARM, B=DISARM, C=CLEAR, D-F ignored
//   keypad_cmd out  command to the alarm FSM (0011 / 1100 / 0000)
//   cmd_active out  high while keypad_cmd is non-zero
//   locked_out out  high during lockout
//   fail_cnt   out  consecutive failure count
//   entry_busy out  high while a PIN is being collected
//   duress     out  duress code was used (latched until reset)

module keypad_code_ctrl #(
    parameter logic [15:0] PIN         = 16'h1234,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 200,
    parameter int unsigned TIMEOUT     = 50,
    parameter int unsigned CMD_HOLD    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ENA,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] keypad_cmd,
    output logic       cmd_active,
    output logic       locked_out,
    output logic [3:0] fail_cnt,
    output logic       entry_busy,
    output logic       duress
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_LOCKOUT
    } state_t;

    localparam logic [3:0]  KEY_ARM    = 4'hA;
    localparam logic [3:0]  KEY_DISARM = 4'hB;
    localparam logic [3:0]  KEY_CLEAR  = 4'hC;
    localparam logic [3:0]  CMD_ARM    = 4'b0011;
    localparam logic [3:0]  CMD_DISARM = 4'b1100;
    localparam logic [3:0]  MAX_FAIL_C = 4'(MAX_FAIL);
    localparam logic [15:0] LOCK_INIT  = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] TMO_INIT   = 16'(TIMEOUT - 1);
    localparam logic [7:0]  HOLD_INIT  = 8'(CMD_HOLD - 1);

    state_t      r_state;
    logic [15:0] r_digits;
    logic [2:0]  r_cnt;
    logic [15:0] r_entry_tmr;
    logic [15:0] r_lock_tmr;
    logic [7:0]  r_hold;
    logic [3:0]  r_cmd;
    logic        r_cmd_active;
    logic        r_locked;
    logic [3:0]  r_fail;
    logic        r_busy;
    logic        r_duress;

    logic        w_key_digit;
    logic        w_key_cmd;
    logic        w_key_clear;
    logic        w_pin_match;
    logic        w_duress_match;
    logic [3:0]  w_fail_next;

    assign w_key_digit = key_valid && (key_code <= 4'd9);
    assign w_key_cmd   = key_valid && ((key_code == KEY_ARM) || (key_code == KEY_DISARM));
    assign w_key_clear = key_valid && (key_code == KEY_CLEAR);
    assign w_pin_match = (r_cnt == 3'd4) && (r_digits == PIN);
    assign w_fail_next = r_fail + 4'd1;

`ifdef KEYPAD_DURESS_EN
    localparam logic [3:0] DURESS_DIGIT = (PIN[3:0] >= 4'd9) ? 4'd0 : PIN[3:0] + 4'd1;
    assign w_duress_match = (r_cnt == 3'd4) && (key_code == KEY_DISARM) &&
                            (r_digits == {PIN[15:4], DURESS_DIGIT});
`else
    assign w_duress_match = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_digits     <= '0;
            r_cnt        <= '0;
            r_entry_tmr  <= '0;
            r_lock_tmr   <= '0;
            r_hold       <= '0;
            r_cmd        <= '0;
            r_cmd_active <= 1'b0;
            r_locked     <= 1'b0;
            r_fail       <= '0;
            r_busy       <= 1'b0;
            r_duress     <= 1'b0;
        end else if (ENA) begin
            case (r_state)
                S_IDLE: begin
                    if (w_key_digit) begin
                        r_digits    <= {r_digits[11:0], key_code};
                        r_cnt       <= 3'd1;
                        r_entry_tmr <= TMO_INIT;
                        r_busy      <= 1'b1;
                        r_state     <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (w_key_digit) begin
                        r_digits    <= {r_digits[11:0], key_code};
                        // Saturate at 7 so over-entry stays distinguishable from 4
                        if (r_cnt != 3'd7)
                            r_cnt <= r_cnt + 3'd1;
                        r_entry_tmr <= TMO_INIT;
                    end else if (w_key_clear) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_key_cmd) begin
                        r_busy <= 1'b0;
                        if (w_pin_match) begin
                            r_cmd        <= (key_code == KEY_ARM) ? CMD_ARM : CMD_DISARM;
                            r_cmd_active <= 1'b1;
                            r_hold       <= HOLD_INIT;
                            r_fail       <= '0;
                            r_state      <= S_ISSUE;
                        end else if (w_duress_match) begin
                            // Looks like a normal disarm; failure count is left alone
                            r_cmd        <= CMD_DISARM;
                            r_cmd_active <= 1'b1;
                            r_hold       <= HOLD_INIT;
                            r_duress     <= 1'b1;
                            r_state      <= S_ISSUE;
                        end else if (w_fail_next == MAX_FAIL_C) begin
                            r_locked   <= 1'b1;
                            r_lock_tmr <= LOCK_INIT;
                            r_fail     <= MAX_FAIL_C;
                            r_state    <= S_LOCKOUT;
                        end else begin
                            r_fail  <= w_fail_next;
                            r_state <= S_IDLE;
                        end
                    end else if (r_entry_tmr == '0) begin
                        // Abandoned entry: silently drop it, no failure counted
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_entry_tmr <= r_entry_tmr - 16'd1;
                    end
                end

                S_ISSUE: begin
                    if (r_hold == '0) begin
                        r_cmd        <= '0;
                        r_cmd_active <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_hold <= r_hold - 8'd1;
                    end
                end

                S_LOCKOUT: begin
                    if (r_lock_tmr == '0) begin
                        r_locked <= 1'b0;
                        r_fail   <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_lock_tmr <= r_lock_tmr - 16'd1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign keypad_cmd = r_cmd;
    assign cmd_active = r_cmd_active;
    assign locked_out = r_locked;
    assign fail_cnt   = r_fail;
    assign entry_busy = r_busy;
    assign duress     = r_duress;

endmodule

// File: tb/tb_keypad_code_ctrl.sv
// tb_keypad_code_ctrl
//   Directed self-checking bench for keypad_code_ctrl with default parameters
//   (PIN 1234, MAX_FAIL 3, LOCK_CYCLES 200, TIMEOUT 50, CMD_HOLD 2).
//   Expected duress behaviour follows KEYPAD_DURESS_EN.

module tb_keypad_code_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ENA;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] keypad_cmd;
    logic       cmd_active;
    logic       locked_out;
    logic [3:0] fail_cnt;
    logic       entry_busy;
    logic       duress;

    int checks = 0;
    int errors = 0;

    keypad_code_ctrl #(
        .PIN        (16'h1234),
        .MAX_FAIL   (3),
        .LOCK_CYCLES(200),
        .TIMEOUT    (50),
        .CMD_HOLD   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ENA       (ENA),
        .key_valid (key_valid),
        .key_code  (key_code),
        .keypad_cmd(keypad_cmd),
        .cmd_active(cmd_active),
        .locked_out(locked_out),
        .fail_cnt  (fail_cnt),
        .entry_busy(entry_busy),
        .duress    (duress)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic press_pin(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
        press(d0);
        press(d1);
        press(d2);
        press(d3);
    endtask

    task automatic test_reset();
        reset = 1'b1; ENA = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({keypad_cmd, cmd_active, locked_out, fail_cnt, entry_busy, duress} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got cmd=%b act=%b lock=%b fail=%0d busy=%b dur=%b required all 0",
                     keypad_cmd, cmd_active, locked_out, fail_cnt, entry_busy, duress);
        end
    endtask

    task automatic test_arm();
        press(4'd1);
        checks++;
        if (entry_busy !== 1'b1) begin
            errors++; $display("FAIL arm_busy: got %b required 1", entry_busy);
        end
        press(4'd2); press(4'd3); press(4'd4);
        press(4'hA);
        checks++;
        if (keypad_cmd !== 4'b0011 || cmd_active !== 1'b1) begin
            errors++; $display("FAIL arm_cmd_c1: got cmd=%b act=%b required 0011/1", keypad_cmd, cmd_active);
        end
        checks++;
        if (entry_busy !== 1'b0 || fail_cnt !== 4'd0) begin
            errors++; $display("FAIL arm_state: got busy=%b fail=%0d required 0/0", entry_busy, fail_cnt);
        end
        tick();
        checks++;
        if (keypad_cmd !== 4'b0011) begin
            errors++; $display("FAIL arm_cmd_c2: got %b required 0011", keypad_cmd);
        end
        tick();
        checks++;
        if (keypad_cmd !== 4'b0000 || cmd_active !== 1'b0 || duress !== 1'b0) begin
            errors++; $display("FAIL arm_cmd_end: got cmd=%b act=%b dur=%b required 0000/0/0",
                               keypad_cmd, cmd_active, duress);
        end
    endtask

    task automatic test_lockout();
        for (int a = 1; a <= 3; a++) begin
            press_pin(4'd1, 4'd2, 4'd3, 4'd6);
            press(4'hB);
            checks++;
            if (fail_cnt !== 4'(a) || keypad_cmd !== 4'b0000 || locked_out !== (a == 3)) begin
                errors++;
                $display("FAIL lock_attempt%0d: got fail=%0d cmd=%b lock=%b required %0d/0000/%b",
                         a, fail_cnt, keypad_cmd, locked_out, a, (a == 3));
            end
        end
        // Correct PIN during lockout must be ignored (5 enabled cycles)
        press_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'hA);
        checks++;
        if (keypad_cmd !== 4'b0000 || entry_busy !== 1'b0 || locked_out !== 1'b1) begin
            errors++; $display("FAIL lock_ignore: got cmd=%b busy=%b lock=%b required 0000/0/1",
                               keypad_cmd, entry_busy, locked_out);
        end
        for (int i = 0; i < 194; i++) tick();
        checks++;
        if (locked_out !== 1'b1 || fail_cnt !== 4'd3) begin
            errors++; $display("FAIL lock_last_cycle: got lock=%b fail=%0d required 1/3", locked_out, fail_cnt);
        end
        tick();
        checks++;
        if (locked_out !== 1'b0 || fail_cnt !== 4'd0) begin
            errors++; $display("FAIL lock_release: got lock=%b fail=%0d required 0/0", locked_out, fail_cnt);
        end
    endtask

    task automatic test_timeout();
        press(4'd1);
        press(4'd2);
        for (int i = 0; i < 49; i++) tick();
        checks++;
        if (entry_busy !== 1'b1) begin
            errors++; $display("FAIL tmo_before: got busy=%b required 1", entry_busy);
        end
        tick();
        checks++;
        if (entry_busy !== 1'b0 || fail_cnt !== 4'd0) begin
            errors++; $display("FAIL tmo_expire: got busy=%b fail=%0d required 0/0", entry_busy, fail_cnt);
        end
        press_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'hB);
        checks++;
        if (keypad_cmd !== 4'b1100 || cmd_active !== 1'b1) begin
            errors++; $display("FAIL tmo_disarm: got cmd=%b act=%b required 1100/1", keypad_cmd, cmd_active);
        end
        tick();
        tick();
    endtask

    task automatic test_over_entry();
        press(4'd9);
        press_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'hA);
        checks++;
        if (fail_cnt !== 4'd1 || keypad_cmd !== 4'b0000) begin
            errors++; $display("FAIL over_entry: got fail=%0d cmd=%b required 1/0000", fail_cnt, keypad_cmd);
        end
        press(4'd1);
        press(4'd2);
        press(4'hC);
        checks++;
        if (entry_busy !== 1'b0 || fail_cnt !== 4'd1) begin
            errors++; $display("FAIL clear: got busy=%b fail=%0d required 0/1", entry_busy, fail_cnt);
        end
        press_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'hA);
        checks++;
        if (keypad_cmd !== 4'b0011 || fail_cnt !== 4'd0) begin
            errors++; $display("FAIL clear_then_arm: got cmd=%b fail=%0d required 0011/0", keypad_cmd, fail_cnt);
        end
        tick();
        tick();
    endtask

    task automatic test_ena_gating();
        press_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'hA);
        ENA = 1'b0;
        tick();
        checks++;
        if (keypad_cmd !== 4'b0011) begin
            errors++; $display("FAIL ena_freeze1: got %b required 0011", keypad_cmd);
        end
        ENA = 1'b1;
        tick();
        ENA = 1'b0;
        tick();
        tick();
        checks++;
        if (keypad_cmd !== 4'b0011) begin
            errors++; $display("FAIL ena_freeze2: got %b required 0011", keypad_cmd);
        end
        ENA = 1'b1;
        tick();
        checks++;
        if (keypad_cmd !== 4'b0000 || cmd_active !== 1'b0) begin
            errors++; $display("FAIL ena_release: got cmd=%b act=%b required 0000/0", keypad_cmd, cmd_active);
        end
    endtask

    task automatic test_reset_mid_issue();
        press_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'hB);
        checks++;
        if (keypad_cmd !== 4'b1100) begin
            errors++; $display("FAIL rst_issue_pre: got %b required 1100", keypad_cmd);
        end
        // Reset with ENA low must still take effect
        ENA = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ENA = 1'b1;
        checks++;
        if (keypad_cmd !== 4'b0000 || cmd_active !== 1'b0) begin
            errors++; $display("FAIL rst_issue: got cmd=%b act=%b required 0000/0", keypad_cmd, cmd_active);
        end
    endtask

    task automatic test_duress();
        press_pin(4'd1, 4'd2, 4'd3, 4'd6);
        press(4'hA);
        press_pin(4'd1, 4'd2, 4'd3, 4'd5);
        press(4'hB);
`ifdef KEYPAD_DURESS_EN
        checks++;
        if (keypad_cmd !== 4'b1100 || duress !== 1'b1 || fail_cnt !== 4'd1) begin
            errors++; $display("FAIL duress_issue: got cmd=%b dur=%b fail=%0d required 1100/1/1",
                               keypad_cmd, duress, fail_cnt);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (duress !== 1'b1 || keypad_cmd !== 4'b0000) begin
            errors++; $display("FAIL duress_hold: got dur=%b cmd=%b required 1/0000", duress, keypad_cmd);
        end
`else
        checks++;
        if (keypad_cmd !== 4'b0000 || duress !== 1'b0 || fail_cnt !== 4'd2) begin
            errors++; $display("FAIL duress_off: got cmd=%b dur=%b fail=%0d required 0000/0/2",
                               keypad_cmd, duress, fail_cnt);
        end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (duress !== 1'b0 || fail_cnt !== 4'd0) begin
            errors++; $display("FAIL duress_reset: got dur=%b fail=%0d required 0/0", duress, fail_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_lockout();
        test_timeout();
        test_over_entry();
        test_ena_gating();
        test_reset_mid_issue();
        test_duress();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
